signal_scan_ctrl: RTL and testbench

Time-shares one activity detector across `N_CH` input lines by scanning them round-robin. For each channel it counts edges over a fixed dwell window and publishes a per-channel presence vector. Changes in presence are reported to the host through a sticky flag with an acknowledge handshake. It sits between the raw front-panel signal inputs and the status/interrupt logic, as the multi-channel counterpart of a single-line signal indicator.

---
 rtl/signal_scan_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_signal_scan_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/signal_scan_ctrl.sv
// -----------------------------------------------------------------------------
// signal_scan_ctrl
//
// Time-shares one edge-counting activity detector across N_CH input lines.
// Channels are visited round-robin. Each unmasked channel gets a 2-cycle settle,
// a DWELL-cycle counting window and a 1-cycle update. A masked channel costs a
// single update cycle and is forced not-present. Presence changes are latched
// into a sticky per-channel change vector that the host clears with i_ack.
//
// Ports
//   i_clk        clock, all logic on the rising edge
//   i_resetn     synchronous active-low reset
//   i_in         asynchronous monitored lines (synchronized internally)
//   i_enable     scanning runs while high; low parks the FSM in IDLE
//   i_mask       1 = channel skipped and forced not-present
//   i_ack        clears pending change report (chg / chg_vec)
//   o_present    registered presence per channel
//   o_chg        sticky "presence changed" flag (OR of o_chg_vec)
//   o_chg_vec    channels whose presence changed since the last ack
//   o_scan_done  1-cycle pulse one cycle after the last channel's update
//   o_cur_ch     channel currently selected
// -----------------------------------------------------------------------------
module signal_scan_ctrl #(
  parameter int N_CH      = 8,
  parameter int DWELL     = 1000,
  parameter int MIN_EDGES = 2
) (
  input  logic                      i_clk,
  input  logic                      i_resetn,
  input  logic [N_CH-1:0]           i_in,
  input  logic                      i_enable,
  input  logic [N_CH-1:0]           i_mask,
  input  logic                      i_ack,
  output logic [N_CH-1:0]           o_present,
  output logic                      o_chg,
  output logic [N_CH-1:0]           o_chg_vec,
  output logic                      o_scan_done,
  output logic [$clog2(N_CH)-1:0]   o_cur_ch
);

  localparam int CH_W = $clog2(N_CH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_DWELL,
    S_UPDATE
  } state_t;

  state_t            r_state;
  state_t            w_next_state;

  logic [N_CH-1:0]   r_sync1;
  logic [N_CH-1:0]   r_sync2;
  logic              r_prev;
  logic [7:0]        r_edges;
  logic [15:0]       r_dwell_cnt;
  logic              r_settle_cnt;
  logic [CH_W-1:0]   r_cur_ch;
  logic [N_CH-1:0]   r_present;
  logic [N_CH-1:0]   r_chg_vec;
  logic              r_chg;
  logic              r_scan_done;

  logic              w_sel;
  logic              w_mask_cur;
  logic              w_last_ch;
  logic [CH_W-1:0]   w_next_ch;
  logic              w_next_masked;
  logic              w_new_val;
  logic              w_changed;

  // Datapath controls decoded from the FSM.
  logic              w_in_settle;
  logic              w_in_dwell;
  logic              w_load_dwell;
  logic              w_do_update;
  logic [N_CH-1:0]   w_ch_onehot;
  logic [N_CH-1:0]   w_chg_vec_nxt;

  assign w_sel         = r_sync2[r_cur_ch];
  assign w_mask_cur    = i_mask[r_cur_ch];
  assign w_last_ch     = (r_cur_ch == CH_W'(N_CH - 1));
  assign w_next_ch     = w_last_ch ? '0 : r_cur_ch + CH_W'(1);
  assign w_next_masked = i_mask[w_next_ch];
  assign w_new_val     = !w_mask_cur && (r_edges >= 8'(MIN_EDGES));
  assign w_changed     = (w_new_val != r_present[r_cur_ch]);

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge i_clk) begin
    if (!i_resetn) r_state <= S_IDLE;
    else           r_state <= w_next_state;
  end

  // ---------------------------------------------------------------------------
  // FSM next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: default assignment first so no path leaves the signal unassigned,
    // which would otherwise infer a latch.
    w_next_state = r_state;
    if (!i_enable) begin
      w_next_state = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE:   w_next_state = w_mask_cur ? S_UPDATE : S_SETTLE;
        S_SETTLE: if (r_settle_cnt) w_next_state = S_DWELL;
        S_DWELL:  if (r_dwell_cnt == 16'd0) w_next_state = S_UPDATE;
        S_UPDATE: w_next_state = w_next_masked ? S_UPDATE : S_SETTLE;
        default:  w_next_state = S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FSM output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    w_in_settle  = (r_state == S_SETTLE);
    w_in_dwell   = (r_state == S_DWELL);
    w_load_dwell = (w_next_state == S_DWELL) && (r_state != S_DWELL);
    // An update with enable low is abandoned, leaving all reported state intact.
    w_do_update  = (r_state == S_UPDATE) && i_enable;

    w_ch_onehot            = '0;
    w_ch_onehot[r_cur_ch]  = 1'b1;

    // Ack drops the bits set before this cycle; a change reported in the same
    // cycle is OR-ed back in afterwards so the new change is never lost.
    w_chg_vec_nxt = i_ack ? '0 : r_chg_vec;
    if (w_do_update && w_changed) w_chg_vec_nxt = w_chg_vec_nxt | w_ch_onehot;
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      r_sync1      <= '0;
      r_sync2      <= '0;
      r_prev       <= 1'b0;
      r_edges      <= '0;
      r_dwell_cnt  <= '0;
      r_settle_cnt <= 1'b0;
      r_cur_ch     <= '0;
      r_present    <= '0;
      r_chg_vec    <= '0;
      r_chg        <= 1'b0;
      r_scan_done  <= 1'b0;
    end else begin
      r_sync1 <= i_in;
      r_sync2 <= r_sync1;

      // Set only while a first settle cycle is followed by a second, so an
      // abandoned settle always restarts with the full two cycles.
      r_settle_cnt <= w_in_settle && (w_next_state == S_SETTLE);

      if (w_in_settle) begin
        r_prev  <= w_sel;
        r_edges <= '0;
      end else if (w_in_dwell) begin
        r_prev <= w_sel;
        if ((w_sel != r_prev) && (r_edges != 8'hFF)) r_edges <= r_edges + 8'd1;
      end

      if (w_load_dwell)                           r_dwell_cnt <= 16'(DWELL - 1);
      else if (w_in_dwell && r_dwell_cnt != 16'd0) r_dwell_cnt <= r_dwell_cnt - 16'd1;

      if (w_do_update) begin
        r_cur_ch <= w_next_ch;
        if (w_changed) r_present[r_cur_ch] <= w_new_val;
      end

      r_chg_vec   <= w_chg_vec_nxt;
      r_chg       <= |w_chg_vec_nxt;
      r_scan_done <= w_do_update && w_last_ch;
    end
  end

  assign o_present   = r_present;
  assign o_chg       = r_chg;
  assign o_chg_vec   = r_chg_vec;
  assign o_scan_done = r_scan_done;
  assign o_cur_ch    = r_cur_ch;

endmodule

// File: tb/tb_signal_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_signal_scan_ctrl
//
// Directed bench for signal_scan_ctrl. Main instance: N_CH=4, DWELL=16,
// MIN_EDGES=2 (unmasked pass = 76 cycles, channel slot = 19 cycles).
// Second instance: N_CH=2, DWELL=600, MIN_EDGES=255, used to exercise the
// saturating edge counter with 300 edges in one window.
// -----------------------------------------------------------------------------
module tb_signal_scan_ctrl;

  logic       clk = 1'b0;
  logic       resetn;
  logic       enable;
  logic       ack;
  logic [3:0] mask;
  logic [3:0] tog;      // channels auto-toggled every 4 cycles
  logic [3:0] tog_val;  // auto-toggle pattern
  logic [3:0] man_val;  // hand-driven pattern
  logic [3:0] w_in;

  logic [3:0] o_present;
  logic       o_chg;
  logic [3:0] o_chg_vec;
  logic       o_scan_done;
  logic [1:0] o_cur_ch;

  logic       en_s;
  logic [1:0] in_s;
  logic [1:0] present_s;
  logic       chg_s;
  logic [1:0] chg_vec_s;
  logic       scan_done_s;
  logic       cur_ch_s;

  int n_checks = 0;
  int n_errors = 0;
  int cyc;

  assign w_in = tog_val ^ man_val;

  always #5 clk = ~clk;

  signal_scan_ctrl #(.N_CH(4), .DWELL(16), .MIN_EDGES(2)) dut (
    .i_clk      (clk),
    .i_resetn   (resetn),
    .i_in       (w_in),
    .i_enable   (enable),
    .i_mask     (mask),
    .i_ack      (ack),
    .o_present  (o_present),
    .o_chg      (o_chg),
    .o_chg_vec  (o_chg_vec),
    .o_scan_done(o_scan_done),
    .o_cur_ch   (o_cur_ch)
  );

  signal_scan_ctrl #(.N_CH(2), .DWELL(600), .MIN_EDGES(255)) dut_s (
    .i_clk      (clk),
    .i_resetn   (resetn),
    .i_in       (in_s),
    .i_enable   (en_s),
    .i_mask     (2'b00),
    .i_ack      (1'b0),
    .o_present  (present_s),
    .o_chg      (chg_s),
    .o_chg_vec  (chg_vec_s),
    .o_scan_done(scan_done_s),
    .o_cur_ch   (cur_ch_s)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Advance negedges until o_scan_done is seen; returns the number of cycles.
  task automatic wait_scan_done(input int budget, output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!o_scan_done && cycles < budget);
    if (!o_scan_done) check("timeout_scan_done", o_scan_done, 1);
  endtask

  task automatic wait_cur_ch(input logic [1:0] target, input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (o_cur_ch != target && n < budget);
    if (o_cur_ch != target) check("timeout_cur_ch", o_cur_ch, target);
  endtask

  task automatic pulse_ack();
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
  endtask

  // Auto-toggle generator for the main instance.
  initial begin
    tog_val = '0;
    forever begin
      repeat (4) @(negedge clk);
      tog_val = tog_val ^ tog;
    end
  end

  // Line 0 of the saturation instance toggles every 2 cycles: 300 edges / 600.
  initial begin
    in_s = '0;
    forever begin
      repeat (2) @(negedge clk);
      in_s[0] = ~in_s[0];
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn  = 1'b0;
    enable  = 1'b0;
    en_s    = 1'b0;
    ack     = 1'b0;
    mask    = 4'b0000;
    tog     = 4'b1000;
    man_val = 4'b0000;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_present",   o_present,   4'b0000);
    check("rst_chg",       o_chg,       1'b0);
    check("rst_chg_vec",   o_chg_vec,   4'b0000);
    check("rst_scan_done", o_scan_done, 1'b0);
    check("rst_cur_ch",    o_cur_ch,    2'd0);
    resetn = 1'b1;
    enable = 1'b1;

    // Square wave on ch 3
    wait_scan_done(200, cyc);
    check("sq_present", o_present, 4'b1000);
    check("sq_chg",     o_chg,     1'b1);
    check("sq_chg_vec", o_chg_vec, 4'b1000);
    wait_scan_done(200, cyc);
    check("sq_pass_len", cyc, 76);
    @(negedge clk);
    check("sq_pulse_width", o_scan_done, 1'b0);

    // Ack clears, then loss of activity on ch 3 is reported
    pulse_ack();
    check("ack_chg",     o_chg,     1'b0);
    check("ack_chg_vec", o_chg_vec, 4'b0000);
    check("ack_present", o_present, 4'b1000);
    tog = 4'b0000;
    wait_scan_done(200, cyc);
    check("loss_present", o_present, 4'b0000);
    check("loss_chg_vec", o_chg_vec, 4'b1000);
    check("loss_chg",     o_chg,     1'b1);

    // Ack in the same cycle as ch 2's UPDATE, where ch 2 becomes present.
    // cur_ch turns 2 at the edge ending ch 1's UPDATE; ch 2's UPDATE is the
    // 19th cycle after that (2 settle + 16 dwell before it).
    tog = 4'b0100;
    wait_cur_ch(2'd2, 200);
    repeat (18) @(negedge clk);
    pulse_ack();
    check("sim_chg_vec", o_chg_vec, 4'b0100);
    check("sim_chg",     o_chg,     1'b1);
    check("sim_present", o_present, 4'b0100);
    tog = 4'b0000;

    // Edge threshold: one edge in ch 1's window (edge lands mid-DWELL)
    wait_cur_ch(2'd1, 200);
    repeat (5) @(negedge clk);
    man_val[1] = 1'b1;
    wait_cur_ch(2'd2, 200);
    check("thr1_present1", o_present[1], 1'b0);

    // Two edges in ch 1's window
    wait_cur_ch(2'd1, 200);
    repeat (5) @(negedge clk);
    man_val[1] = 1'b0;
    repeat (4) @(negedge clk);
    man_val[1] = 1'b1;
    wait_cur_ch(2'd2, 200);
    check("thr2_present1", o_present[1], 1'b1);
    check("thr2_chg_vec1", o_chg_vec[1], 1'b1);

    // Saturation: 300 edges, threshold 255 only reachable if counter saturates
    en_s = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!scan_done_s && cyc < 3000);
    check("sat_scan_done", scan_done_s, 1'b1);
    check("sat_present",   present_s,   2'b01);
    check("sat_chg_vec",   chg_vec_s,   2'b01);

    // Masking: first all channels present, then mask 0101
    tog = 4'b1111;
    wait_scan_done(200, cyc);
    wait_scan_done(200, cyc);
    check("all_present", o_present, 4'b1111);
    pulse_ack();
    check("all_ack_chg", o_chg, 1'b0);
    mask = 4'b0101;
    wait_scan_done(200, cyc);
    check("mask_present", o_present, 4'b1010);
    check("mask_chg_vec", o_chg_vec, 4'b0101);
    check("mask_chg",     o_chg,     1'b1);
    wait_scan_done(200, cyc);
    check("mask_pass_len", cyc, 40);
    check("mask_present2", o_present, 4'b1010);

    // Enable drop during ch 1's DWELL
    mask = 4'b0000;
    wait_scan_done(200, cyc);
    wait_scan_done(200, cyc);
    check("unmask_present", o_present, 4'b1111);
    pulse_ack();
    wait_cur_ch(2'd1, 200);
    repeat (6) @(negedge clk);
    enable = 1'b0;
    repeat (5) @(negedge clk);
    check("dis_cur_ch",    o_cur_ch,    2'd1);
    check("dis_present",   o_present,   4'b1111);
    check("dis_chg",       o_chg,       1'b0);
    check("dis_chg_vec",   o_chg_vec,   4'b0000);
    check("dis_scan_done", o_scan_done, 1'b0);
    enable = 1'b1;
    // Fresh SETTLE on ch 1: cur_ch advances on the 20th edge after re-enable.
    repeat (19) @(negedge clk);
    check("reen_cur_ch_hold", o_cur_ch, 2'd1);
    @(negedge clk);
    check("reen_cur_ch_next", o_cur_ch, 2'd2);
    check("reen_present",     o_present, 4'b1111);

    // Reset mid-DWELL on ch 3
    wait_cur_ch(2'd3, 200);
    repeat (6) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    check("mrst_present", o_present, 4'b0000);
    check("mrst_chg",     o_chg,     1'b0);
    check("mrst_chg_vec", o_chg_vec, 4'b0000);
    check("mrst_cur_ch",  o_cur_ch,  2'd0);
    enable = 1'b0;
    resetn = 1'b1;
    repeat (30) @(negedge clk);
    check("idle_cur_ch",    o_cur_ch,    2'd0);
    check("idle_present",   o_present,   4'b0000);
    check("idle_scan_done", o_scan_done, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
